// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the stream reader, the FIFO it drains, and the
// downstream consumer. The master side is the reader itself.
interface fifo_stream_reader_if #(
  parameter int DWIDTH = 16
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DWIDTH-1:0] fifo_dout;
  logic              m_valid;
  logic [DWIDTH-1:0] m_data;
  logic              m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO with registered read data into a valid/ready stream.
// A 2-entry skid buffer plus one in-flight flag lets the reader keep a read
// outstanding every cycle without ever overrunning the buffer.
module fifo_stream_reader #(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  output logic [CWIDTH-1:0] rd_count,
  fifo_stream_reader_if.master bus
);

  logic [DWIDTH-1:0] head_q;
  logic [DWIDTH-1:0] tail_q;
  logic [1:0]        occ;
  logic              pend;

  logic              pop;
  logic              capture;
  logic [2:0]        fill_after_pop;
  logic [1:0]        occ_nxt;
  logic [DWIDTH-1:0] head_nxt;
  logic [DWIDTH-1:0] tail_nxt;

  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = head_q;

  // Issue a read only if the word it returns is guaranteed a free slot.
  always_comb begin
    pop            = bus.m_valid & bus.m_ready;
    // pop implies occ >= 1, so this difference never goes negative.
    fill_after_pop = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    bus.fifo_rd_en = rstn & ~flush & ~bus.fifo_empty & (fill_after_pop < 3'd2);
  end

  // Next buffer contents from the capture/pop combination; flush empties it.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    occ_nxt  = occ;
    head_nxt = head_q;
    tail_nxt = tail_q;
    capture  = pend & ~flush;
    if (flush) begin
      occ_nxt = 2'd0;
    end else begin
      case ({capture, pop})
        2'b01: begin
          head_nxt = tail_q;
          occ_nxt  = occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) head_nxt = bus.fifo_dout;
          else             tail_nxt = bus.fifo_dout;
          occ_nxt = occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_nxt = bus.fifo_dout;
          end else begin
            head_nxt = tail_q;
            tail_nxt = bus.fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous active-low reset taking priority over flush.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (!rstn) begin
      occ      <= 2'd0;
      pend     <= 1'b0;
      rd_count <= '0;
      // NOTE: the buffer entries are reset because m_data is observable and must read 0.
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      occ      <= occ_nxt;
      pend     <= bus.fifo_rd_en;
      head_q   <= head_nxt;
      tail_q   <= tail_nxt;
      rd_count <= rd_count + CWIDTH'(pop);
    end
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DWIDTH, default 16: data word width; SHALL match the attached FIFO DWIDTH.
REQ-002 Parameter CWIDTH, default 16: width of the delivered-word counter.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 fifo_empty  input  1  FIFO empty flag.
REQ-006 fifo_rd_en  output  1  FIFO read enable.
REQ-007 fifo_dout  input  DWIDTH  FIFO read data; registered, valid the cycle after a successful read.
REQ-008 flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-009 m_valid  output  1  output stream word valid.
REQ-010 m_data  output  DWIDTH  output stream word.
REQ-011 m_ready  input  1  downstream accepts the word.
REQ-012 rd_count  output  CWIDTH  count of words accepted downstream.

Function
REQ-013 Internal state SHALL be a 2-entry ordered skid buffer (occ 0..2) plus one in-flight flag pend.
REQ-014 Define pop = m_valid & m_ready; a transfer SHALL occur exactly on cycles where pop = 1.
REQ-015 fifo_rd_en SHALL be combinational: 1 iff rstn = 1, flush = 0, fifo_empty = 0 and (occ + pend - pop) < 2.
REQ-016 fifo_rd_en SHALL never be 1 while fifo_empty = 1.
REQ-017 pend SHALL be set to 1 on the edge ending a cycle with fifo_rd_en = 1, else cleared.
REQ-018 When pend = 1 and flush = 0, fifo_dout SHALL be written into the buffer tail on that edge.
REQ-019 m_valid SHALL equal (occ != 0); m_data SHALL be the head entry, held stable while m_valid = 1 and m_ready = 0.
REQ-020 Latency: fifo_rd_en in cycle N -> word captured at end of N+1 -> m_valid in cycle N+2 when the buffer was empty.
REQ-021 Throughput: with fifo_empty = 0 and m_ready = 1 continuously, SHALL deliver one word per cycle after the initial 2-cycle latency.
REQ-022 Simultaneous capture and pop: occ SHALL stay unchanged, head advances, order preserved.
REQ-023 Capture with occ = 2 SHALL be impossible by construction of REQ-015; a bench assertion SHALL check it.
REQ-024 Words SHALL exit in FIFO read order, none duplicated or dropped (except by flush).
REQ-025 flush = 1: fifo_rd_en = 0; at the edge occ -> 0 and pend -> 0; any word arriving that cycle SHALL be discarded; pop in the flush cycle SHALL still count.
REQ-026 rd_count SHALL increment by 1 on each pop, wrapping from 2^CWIDTH-1 to 0; flush SHALL NOT clear it.
REQ-027 m_ready SHALL have no effect while m_valid = 0.

Reset
REQ-028 While rstn = 0: fifo_rd_en = 0 combinationally; at the edge occ = 0, pend = 0, m_valid = 0, m_data = 0, rd_count = 0.
REQ-029 Reset mid-operation SHALL discard buffered and in-flight words; the first cycle after release behaves as REQ-015 with occ = pend = 0.
REQ-030 Reset SHALL take priority over flush and all other inputs.

Verification
REQ-031 FIFO preloaded 0x0001..0x0005, m_ready = 1 -> m_valid first high 2 cycles after first fifo_rd_en; 5 consecutive words in order; rd_count = 5.
REQ-032 FIFO holds 4 words, m_ready = 0 -> exactly 2 reads issued, occ = 2, fifo_rd_en then 0; m_data = first word stable; raising m_ready delivers all 4 in order.
REQ-033 m_ready toggling 1/0 each cycle with continuous data -> no loss or duplication over 100 words; occ never exceeds 2.
REQ-034 flush asserted 1 cycle after a read issued with occ = 1 -> next cycle m_valid = 0, in-flight word absent from output; rd_count unchanged.
REQ-035 rstn low for 1 cycle with occ = 2 -> m_valid = 0, rd_count = 0, m_data = 0; subsequent words delivered normally.
REQ-036 CWIDTH = 4, 17 transfers -> rd_count = 1 (wrap at 16).
